// File: rtl/simon_game_core.sv
// Simon memory-game engine: replays an LFSR-generated sequence and checks the player's presses.
// Define SIMON_TIMEOUT_EN to build the WAIT_IN input timeout (TIMEOUT_TICKS).
module simon_game_core #(
    parameter int NUM_BUTTONS   = 4,
    parameter int MAX_LEN       = 16,
    parameter int TICK_DIV      = 50000,
    parameter int SHOW_TICKS    = 8,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   start,
    input  logic [15:0]            seed_in,
    input  logic [NUM_BUTTONS-1:0] btn,
    output logic [NUM_BUTTONS-1:0] led,
    output logic [7:0]             score,
    output logic                   busy,
    output logic                   win,
    output logic                   lose
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHOW_ON  = 3'd1;
    localparam logic [2:0] S_SHOW_OFF = 3'd2;
    localparam logic [2:0] S_WAIT_IN  = 3'd3;
    localparam logic [2:0] S_WAIT_REL = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;
    localparam logic [2:0] S_WIN      = 3'd6;
    localparam logic [2:0] S_LOSE     = 3'd7;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (SHOW_TICKS > GAP_TICKS)
                             ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                             : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int TW = $clog2(MAX_TICKS + 1);

    localparam logic [PW-1:0] TICK_LAST    = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
`endif
    localparam logic [7:0]    LEN_MAX      = 8'(MAX_LEN);
    localparam logic [3:0]    NB4          = 4'(NUM_BUTTONS);

    logic [2:0]             state, state_d;
    logic [NUM_BUTTONS-1:0] led_d, expect_oh;
    logic [15:0]            lfsr, lfsr_d, seed, seed_d, free_cnt;
    logic [7:0]             len, len_d, idx, idx_d, score_d;
    logic [PW-1:0]          presc;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Low three LFSR bits fold into the button range by a single subtraction.
    function automatic logic [NUM_BUTTONS-1:0] sym_onehot(input logic [2:0] v);
        logic [3:0]             v4, s4;
        logic [NUM_BUTTONS-1:0] oh;
        v4 = {1'b0, v};
        s4 = (v4 < NB4) ? v4 : v4 - NB4;
        for (int i = 0; i < NUM_BUTTONS; i++) oh[i] = (s4 == 4'(i));
        return oh;
    endfunction

    assign tick      = (presc == TICK_LAST);
    assign expect_oh = sym_onehot(lfsr[2:0]);
    assign busy      = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign win       = (state == S_WIN);
    assign lose      = (state == S_LOSE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        led_d   = led;
        lfsr_d  = lfsr;
        seed_d  = seed;
        len_d   = len;
        idx_d   = idx;
        score_d = score;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    seed_d  = (seed_in != 16'd0) ? seed_in : (free_cnt | 16'd1);
                    lfsr_d  = seed_d;
                    len_d   = 8'd1;
                    idx_d   = 8'd0;
                    score_d = 8'd0;
                    state_d = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (tick && tick_cnt == SHOW_LAST) begin
                    led_d   = '0;
                    lfsr_d  = lfsr_step(lfsr);
                    idx_d   = idx + 8'd1;
                    state_d = S_SHOW_OFF;
                end
            end
            S_SHOW_OFF: begin
                if (tick && tick_cnt == GAP_LAST) begin
                    if (idx == len) begin
                        lfsr_d  = seed;
                        idx_d   = 8'd0;
                        state_d = S_WAIT_IN;
                    end else begin
                        state_d = S_SHOW_ON;
                    end
                end
            end
            S_WAIT_IN: begin
                led_d = '0;
                if (btn != '0) begin
                    if (btn == expect_oh) begin
                        led_d   = btn;
                        lfsr_d  = lfsr_step(lfsr);
                        state_d = S_WAIT_REL;
                    end else begin
                        led_d   = expect_oh;
                        state_d = S_LOSE;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tick && tick_cnt == TIMEOUT_LAST) begin
                    led_d   = expect_oh;
                    state_d = S_LOSE;
                end
`endif
            end
            S_WAIT_REL: begin
                // led still holds the accepted one-hot press, which is the symbol to show on a loss.
                if (btn == '0) begin
                    idx_d = idx + 8'd1;
                    led_d = '0;
                    if (idx_d == len) begin
                        score_d = (score == 8'hFF) ? score : score + 8'd1;
                        if (len == LEN_MAX) begin
                            led_d   = '1;
                            state_d = S_WIN;
                        end else begin
                            len_d   = len + 8'd1;
                            state_d = S_GAP;
                        end
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end else if (btn != led) begin
                    state_d = S_LOSE;
                end
            end
            S_GAP: begin
                led_d = '0;
                if (tick && tick_cnt == GAP_LAST) begin
                    lfsr_d  = seed;
                    idx_d   = 8'd0;
                    state_d = S_SHOW_ON;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_SHOW_ON) led_d = sym_onehot(lfsr_d[2:0]);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= S_IDLE;
            led      <= '0;
            score    <= 8'd0;
            len      <= 8'd1;
            idx      <= 8'd0;
            presc    <= '0;
            tick_cnt <= '0;
            seed     <= 16'h0001;
            lfsr     <= 16'h0001;
            free_cnt <= 16'd0;
        end else if (ena) begin
            free_cnt <= free_cnt + 16'd1;
            state    <= state_d;
            led      <= led_d;
            score    <= score_d;
            len      <= len_d;
            idx      <= idx_d;
            seed     <= seed_d;
            lfsr     <= lfsr_d;
            // Timing restarts on every state change so each state lasts whole ticks.
            if (state_d != state) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_simon_game_core.sv
// Randomised self-checking bench for simon_game_core against a sequence-level game model.
module tb_simon_game_core;

    localparam int NB = 4;
    localparam int ML = 3;
    localparam int TD = 2;
    localparam int ST = 3;
    localparam int GT = 1;
    localparam int TO = 4;
    localparam int SHOW_CYC = ST * TD;
    localparam int GAP_CYC  = GT * TD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   seed_in = 16'd0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] led;
    logic [7:0]    score;
    logic          busy, win, lose;

    int n_vec = 0;
    int n_err = 0;
    int seq [ML];
    int m_len, m_score;

    always #5 clk = ~clk;

    simon_game_core #(
        .NUM_BUTTONS(NB), .MAX_LEN(ML), .TICK_DIV(TD),
        .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .seed_in(seed_in),
        .btn(btn), .led(led), .score(score), .busy(busy), .win(win), .lose(lose)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] oh(input int s);
        logic [NB-1:0] r;
        r = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    // Whole game sequence from the seed, using plain integer arithmetic.
    task automatic new_sequence(input int s);
        int r, v;
        r = s;
        for (int i = 0; i < ML; i++) begin
            v = r % 8;
            seq[i] = (v < NB) ? v : v - NB;
            r = (r % 2 == 1) ? ((r / 2) ^ 'hB400) : (r / 2);
        end
    endtask

    task automatic start_game(input int s);
        seed_in = 16'(s);
        start = 1'b1;
        new_sequence(s);
        m_len = 1;
        m_score = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic playback();
        for (int i = 0; i < m_len; i++) begin
            check("show_busy", busy, 1);
            for (int c = 0; c < SHOW_CYC; c++) begin
                check("show_led", led, oh(seq[i]));
                @(negedge clk);
            end
            for (int c = 0; c < GAP_CYC; c++) begin
                check("show_gap_led", led, 0);
                @(negedge clk);
            end
        end
        check("wait_in_led", led, 0);
        check("wait_in_busy", busy, 1);
    endtask

    task automatic check_lost(input logic [NB-1:0] exp_led, input bit led_known);
        check("lose_flag", lose, 1);
        check("lose_busy", busy, 0);
        check("lose_win", win, 0);
        check("lose_score", score, m_score);
        if (led_known) check("lose_led", led, exp_led);
    endtask

    task automatic play_round(input int err_pct, output bit over);
        logic [NB-1:0] want, w;
        int r;
        over = 1'b0;
        if ($urandom_range(3) == 0) begin
            start = 1'b1;
            seed_in = 16'($urandom_range(1, 65535));
            @(negedge clk);
            start = 1'b0;
            check("start_ignored_busy", busy, 1);
            check("start_ignored_led", led, 0);
        end
        repeat ($urandom_range(2)) begin
            @(negedge clk);
            check("idle_led", led, 0);
        end
        for (int i = 0; i < m_len; i++) begin
            want = oh(seq[i]);
            r = $urandom_range(99);
            if (r < err_pct / 2) begin
                do w = NB'($urandom_range(1, (1 << NB) - 1)); while (w == want);
                btn = w;
                @(negedge clk);
                check_lost(want, 1'b1);
                btn = '0;
                over = 1'b1;
                return;
            end
            btn = want;
            @(negedge clk);
            check("held_led", led, want);
            repeat ($urandom_range(3)) begin
                @(negedge clk);
                check("held_led", led, want);
            end
            if (r < err_pct) begin
                btn = oh((seq[i] + $urandom_range(1, NB - 1)) % NB);
                @(negedge clk);
                check_lost(want, 1'b0);
                btn = '0;
                over = 1'b1;
                return;
            end
            btn = '0;
            @(negedge clk);
            if (i < m_len - 1) check("next_wait_led", led, 0);
        end
        m_score++;
        check("round_score", score, m_score);
        if (m_len == ML) begin
            check("win_flag", win, 1);
            check("win_led", led, {NB{1'b1}});
            check("win_busy", busy, 0);
            check("win_lose", lose, 0);
            over = 1'b1;
        end else begin
            m_len++;
            for (int c = 0; c < GAP_CYC; c++) begin
                check("round_gap_led", led, 0);
                @(negedge clk);
            end
        end
    endtask

    task automatic run_game(input int s, input int err_pct);
        bit over;
        start_game(s);
        playback();
        over = 1'b0;
        while (!over) begin
            play_round(err_pct, over);
            if (!over) playback();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start asserted: start must be ignored.
        start = 1'b1;
        seed_in = 16'h0007;
        repeat (2) @(negedge clk);
        check("rst_led", led, 0);
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst_busy", busy, 0);
        check("idle_after_rst_led", led, 0);

        // Known-seed playback, then idle in WAIT_IN.
        start_game(16'h0007);
        check("first_led", led, 4'b1000);
        playback();
        for (int c = 0; c < TO * TD; c++) begin
            check("pre_timeout_lose", lose, 0);
            @(negedge clk);
        end
`ifdef SIMON_TIMEOUT_EN
        check("timeout_lose", lose, 1);
        check("timeout_led", led, 4'b1000);
        start_game(16'h0007);
        playback();
`else
        repeat (1000) @(negedge clk);
        check("no_timeout_lose", lose, 0);
        check("no_timeout_busy", busy, 1);
`endif
        // Wrong single press in round 1.
        btn = 4'b0001;
        @(negedge clk);
        check_lost(4'b1000, 1'b1);
        btn = '0;

        // Two buttons at once.
        start_game(16'h0007);
        playback();
        btn = 4'b1001;
        @(negedge clk);
        check_lost(4'b1000, 1'b1);
        btn = '0;

        // Enable held low for 10 cycles in SHOW_ON stretches it by exactly 10 cycles.
        start_game(16'h0007);
        for (int c = 0; c < 3; c++) begin
            check("ena_pre_led", led, 4'b1000);
            @(negedge clk);
        end
        ena = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("ena_hold_led", led, 4'b1000);
            @(negedge clk);
        end
        ena = 1'b1;
        for (int c = 0; c < SHOW_CYC - 3; c++) begin
            check("ena_post_led", led, 4'b1000);
            @(negedge clk);
        end
        for (int c = 0; c < GAP_CYC; c++) begin
            check("ena_gap_led", led, 0);
            @(negedge clk);
        end
        check("ena_wait_busy", busy, 1);

        // Reset in the middle of a press aborts the game.
        btn = 4'b1000;
        @(negedge clk);
        check("pre_abort_led", led, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_led", led, 0);
        check("abort_busy", busy, 0);
        check("abort_score", score, 0);
        rst_n = 1'b1;
        btn = '0;
        @(negedge clk);

        // Error-free game to the win, then randomised games with mistakes.
        run_game(16'h0007, 0);
        for (int g = 0; g < 25; g++) run_game($urandom_range(1, 65535), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
